// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand sequencer states, opcodes and widths.
// Imported by the operand front end and the ALU stages.
package alu_pkg;

  localparam int ALU_N   = 4;
  localparam int ALU_OPW = 4;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    READY   = 2'd3
  } seq_state_t;

  localparam logic [ALU_OPW-1:0] ALU_OP_ADD = 4'd0;
  localparam logic [ALU_OPW-1:0] ALU_OP_SUB = 4'd1;
  localparam logic [ALU_OPW-1:0] ALU_OP_AND = 4'd2;
  localparam logic [ALU_OPW-1:0] ALU_OP_SRL = 4'd3;
  localparam logic [ALU_OPW-1:0] ALU_OP_OR  = 4'd4;
  localparam logic [ALU_OPW-1:0] ALU_OP_XOR = 4'd5;

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector on a synchronised level.
// RST_VAL=1 suppresses an edge for a level already high at reset release.
module rise_edge_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) r_prev <= RST_VAL;
    else     r_prev <= in;
  end

  assign pulse = in & ~r_prev;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Captures A, B/shift amount and opcode from one switch bus over three
// load presses, then holds them and pulses start once.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int N   = ALU_N,
  parameter int OPW = ALU_OPW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   sw,
  input  logic           btn_load,
  input  logic           btn_clear,
  output logic [N-1:0]   a,
  output logic [N-1:0]   b,
  output logic [OPW-1:0] op,
  output logic [1:0]     stage,
  output logic           start,
  output logic           valid
);

  generate
    if (N < OPW) begin : g_bad_width
      $error("alu_operand_sequencer: N must be >= OPW");
    end
  endgenerate

  logic           w_ld;
  seq_state_t     r_state;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [OPW-1:0] r_op;
  logic           r_start;

  // Edge flop is not cleared by btn_clear; it keeps tracking the button.
  rise_edge_detect #(
    .RST_VAL(1'b1)
  ) u_ld (
    .clk  (clk),
    .rst  (rst),
    .in   (btn_load),
    .pulse(w_ld)
  );

  always_ff @(posedge clk) begin
    if (rst || btn_clear) begin
      r_state <= LOAD_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_start <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (w_ld) begin
        unique case (r_state)
          LOAD_A: begin
            r_a     <= sw;
            r_state <= LOAD_B;
          end
          LOAD_B: begin
            r_b     <= sw;
            r_state <= LOAD_OP;
          end
          LOAD_OP: begin
            r_op    <= sw[OPW-1:0];
            r_start <= 1'b1;
            r_state <= READY;
          end
          READY: begin
            r_a     <= sw;
            r_state <= LOAD_B;
          end
        endcase
      end
    end
  end

  assign a     = r_a;
  assign b     = r_b;
  assign op    = r_op;
  assign stage = r_state;
  assign start = r_start;
  assign valid = (r_state == READY);

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       btn_load;
  logic       btn_clear;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] op;
  logic [1:0] stage;
  logic       start;
  logic       valid;

  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;

  alu_operand_sequencer #(.N(4), .OPW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .btn_load (btn_load),
    .btn_clear(btn_clear),
    .a        (a),
    .b        (b),
    .op       (op),
    .stage    (stage),
    .start    (start),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] v);
    @(negedge clk);
    sw       = v;
    btn_load = 1'b1;
    @(negedge clk);
    btn_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sw = '0; btn_load = 1'b0; btn_clear = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_a", {4'h0, a}, 8'h0);
    chk("rst_b", {4'h0, b}, 8'h0);
    chk("rst_op", {4'h0, op}, 8'h0);
    chk("rst_stage", {6'h0, stage}, 8'h0);
    chk("rst_start", {7'h0, start}, 8'h0);
    chk("rst_valid", {7'h0, valid}, 8'h0);
    rst = 1'b0;

    // full sequence
    press(4'b1010);
    chk("seq_a1", {4'h0, a}, 8'h0a);
    chk("seq_stage1", {6'h0, stage}, 8'h1);
    press(4'b0001);
    chk("seq_b", {4'h0, b}, 8'h01);
    chk("seq_stage2", {6'h0, stage}, 8'h2);
    chk("seq_start_pre", {7'h0, start}, 8'h0);
    @(negedge clk);
    sw = 4'b0011; btn_load = 1'b1;
    @(negedge clk);
    chk("seq_start_hi", {7'h0, start}, 8'h1);
    chk("seq_op", {4'h0, op}, 8'h03);
    chk("seq_stage3", {6'h0, stage}, 8'h3);
    chk("seq_valid", {7'h0, valid}, 8'h1);
    chk("seq_a_hold", {4'h0, a}, 8'h0a);
    chk("seq_srl_y", {4'h0, a >> b}, 8'h05);
    btn_load = 1'b0;
    @(negedge clk);
    chk("seq_start_lo", {7'h0, start}, 8'h0);

    // reload from READY
    press(4'b0110);
    chk("rdy_a", {4'h0, a}, 8'h06);
    chk("rdy_b", {4'h0, b}, 8'h01);
    chk("rdy_op", {4'h0, op}, 8'h03);
    chk("rdy_stage", {6'h0, stage}, 8'h1);
    chk("rdy_valid", {7'h0, valid}, 8'h0);

    // held button yields one ld
    @(negedge clk); btn_clear = 1'b1;
    @(negedge clk); btn_clear = 1'b0;
    chk("clr_stage", {6'h0, stage}, 8'h0);
    chk("clr_a", {4'h0, a}, 8'h0);
    sw = 4'b1111; btn_load = 1'b1;
    repeat (10) @(negedge clk);
    chk("hold_a", {4'h0, a}, 8'h0f);
    chk("hold_b", {4'h0, b}, 8'h0);
    chk("hold_stage", {6'h0, stage}, 8'h1);
    btn_load = 1'b0;
    @(negedge clk);
    chk("hold_rel_stage", {6'h0, stage}, 8'h1);
    press(4'b0010);
    chk("hold_repress_b", {4'h0, b}, 8'h02);
    chk("hold_repress_st", {6'h0, stage}, 8'h2);

    // clear beats ld in LOAD_OP
    @(negedge clk); btn_clear = 1'b1;
    @(negedge clk); btn_clear = 1'b0;
    press(4'b1100);
    press(4'b0010);
    chk("cl_pre_stage", {6'h0, stage}, 8'h2);
    n_start = 0;
    @(negedge clk);
    sw = 4'b0011; btn_load = 1'b1; btn_clear = 1'b1;
    @(negedge clk);
    n_start += int'(start);
    chk("cl_a", {4'h0, a}, 8'h0);
    chk("cl_b", {4'h0, b}, 8'h0);
    chk("cl_op", {4'h0, op}, 8'h0);
    chk("cl_stage", {6'h0, stage}, 8'h0);
    btn_load = 1'b0; btn_clear = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_start += int'(start);
    end
    chk("cl_no_start", n_start[7:0], 8'h0);

    // button held through reset release
    rst = 1'b1; btn_load = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rhold_stage", {6'h0, stage}, 8'h0);
    chk("rhold_a", {4'h0, a}, 8'h0);
    btn_load = 1'b0;
    press(4'b1000);
    chk("rhold_a2", {4'h0, a}, 8'h08);

    // reset mid-sequence
    @(negedge clk); btn_clear = 1'b1;
    @(negedge clk); btn_clear = 1'b0;
    press(4'b0101);
    chk("mid_a", {4'h0, a}, 8'h05);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_a0", {4'h0, a}, 8'h0);
    chk("mid_stage0", {6'h0, stage}, 8'h0);
    chk("mid_valid0", {7'h0, valid}, 8'h0);
    press(4'b1111);
    press(4'b0010);
    press(4'b0011);
    chk("re_a", {4'h0, a}, 8'h0f);
    chk("re_b", {4'h0, b}, 8'h02);
    chk("re_op", {4'h0, op}, 8'h03);
    chk("re_valid", {7'h0, valid}, 8'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Upstream front end of the ALU datapath; feeds the operand and shift-amount inputs of the ALU stages, including right_logic_shifter (a→a, b→shift).
- Captures operand A, operand B/shift amount, and opcode from one shared switch bus over three successive load-button presses.
- Holds the captured values stable and emits a one-cycle start pulse when the operand set is complete.

Parameters:
- N, 4, datapath width of sw, a and b.
- OPW, 4, opcode width; N >= OPW is required (elaboration-time assertion).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- sw  input  N  shared data input (switches).
- btn_load  input  1  load button level, already debounced and synchronised; rising edge = load event.
- btn_clear  input  1  synchronous clear, level-sensitive.
- a  output  N  registered operand A.
- b  output  N  registered operand B / shift amount.
- op  output  OPW  registered opcode.
- stage  output  2  current FSM state encoding.
- start  output  1  one-cycle pulse when the opcode is captured.
- valid  output  1  high while a complete operand set is held.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst). All state updates occur on the rising edge of clk.
- Load event: `ld = btn_load & ~btn_prev`, where btn_prev is btn_load registered.
  - btn_prev resets to 1, so a button held through reset release produces no event until it is released and pressed again.
- FSM states and stage encoding: LOAD_A=0, LOAD_B=1, LOAD_OP=2, READY=3.
  - LOAD_A on ld: a <= sw; go to LOAD_B.
  - LOAD_B on ld: b <= sw; go to LOAD_OP.
  - LOAD_OP on ld: op <= sw[OPW-1:0]; start <= 1; go to READY.
  - READY on ld: a <= sw; go to LOAD_B. b and op keep their old values until overwritten.
  - Without ld, the state and all registers hold.
- start is registered: it is high for exactly the one cycle after the edge that captures op, and 0 otherwise.
- valid = (state == READY). It is registered or decoded from the state register; no combinational path from the inputs.
- Latency: a, b and op are visible the cycle after the edge at which ld is sampled high. Only one field is captured per ld; multiple fields are never captured in one cycle.
- Reset (rst=1): state=LOAD_A, a=0, b=0, op=0, start=0, valid=0, stage=0, btn_prev=1.
  - Reset applied mid-sequence discards any partial capture.
- Clear (btn_clear=1): identical to reset except that btn_prev tracks btn_load normally.
  - Priority: rst > btn_clear > ld. A clear in the same cycle as ld wins; nothing is captured.
- Holding btn_load high across many cycles yields exactly one ld.
- The value of sw is not checked; any N-bit value, including a shift amount >= N, is passed through unchanged.
- No combinational path from any input to any output.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [1:0] seq_state_t {LOAD_A, LOAD_B, LOAD_OP, READY}.
  - Opcode localparams shared with the ALU, including ALU_OP_SRL.
  - Default width localparam ALU_N = 4.
- Sub-module rise_edge_detect (clk, rst, in, pulse), with a reset value parameter for its delay flop (set to 1 here). It provides ld.
- The FSM and the capture registers remain in alu_operand_sequencer.

Test Plan:
- Reset, then sw=4'b1010 ld; sw=4'b0001 ld; sw=4'b0011 ld → a=1010, b=0001, op=0011, stage=3, valid=1. start high exactly one cycle after the third edge. The shifter fed a/b gives y=0101.
- btn_load held high 10 cycles in LOAD_A with sw=4'b1111 → a=1111 captured once, stage=1, a second field is not captured, stays in LOAD_B until release and re-press.
- In LOAD_OP (a=1100, b=0010), assert btn_clear in the same cycle as an ld edge → a=0, b=0, op=0, stage=0, start never pulses.
- In READY (a=1010, b=0001, op=0011), press ld with sw=4'b0110 → a=0110, b=0001 and op=0011 unchanged, stage=1, valid=0.
- btn_load high while rst=1, rst then deasserted with btn_load still high → no capture and stage=0. After release and press with sw=4'b1000, a=1000.
- rst asserted for one cycle in LOAD_B after a=0101 → all outputs zero on the next cycle, stage=0. A full re-sequence with sw 1111/0010/0011 gives a=1111, b=0010, valid=1.
